// File: rtl/ov7670_config.sv
// OV7670 register configuration sequencer.
// Walks a register ROM of {sub_address, data} entries and hands each write to an
// SCCB master. Two ROM values are reserved: 16'hFFFF ends the sequence and
// 16'hFFF0 inserts a DELAY_CYCLES pause. After each write the block idles for
// GUARD_CYCLES before fetching the next entry.
// Optional feature: define OV7670_CFG_TIMEOUT_EN to add a cfg_error output and
// a watchdog that aborts the sequence when the SCCB master stops reporting phases.
module ov7670_config #(
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned DELAY_CYCLES   = 1_000_000,
  parameter int unsigned GUARD_CYCLES   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sub_address,
  output logic [7:0]        data,
  input  logic              one_phase_done,
  output logic              cfg_busy,
  output logic              cfg_done
`ifdef OV7670_CFG_TIMEOUT_EN
  , output logic            cfg_error
`endif
);

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    SEND,
    WAIT_PH,
    GUARD,
    DELAY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] cnt;
  logic [1:0]  phase_cnt;
  logic        last_phase;
  logic        cnt_expire;
  logic        at_last_addr;
  logic        wdog_expire;

  // Reject parameter values the counters cannot honour at elaboration time.
  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ov7670_config: GUARD_CYCLES must be 1..255 and TIMEOUT_CYCLES at least 1");
  end

  assign last_phase   = one_phase_done && (phase_cnt == 2'd2);
  assign cnt_expire   = (cnt <= 32'd1);
  assign at_last_addr = (rom_addr == {ROM_AW{1'b1}});

`ifdef OV7670_CFG_TIMEOUT_EN
  logic [31:0] wdog;

  // The watchdog only fires on a clock with no phase pulse; a pulse always reloads it.
  assign wdog_expire = !one_phase_done && (wdog <= 32'd1);

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog      <= '0;
      cfg_error <= 1'b0;
    end else begin
      if (state == IDLE && cfg_start) begin
        cfg_error <= 1'b0;
      end
      if (state == SEND || (state == WAIT_PH && one_phase_done)) begin
        wdog <= TIMEOUT_CYCLES;
      end else if (state == WAIT_PH && wdog != '0) begin
        wdog <= wdog - 32'd1;
      end
      if (state == WAIT_PH && wdog_expire) begin
        cfg_error <= 1'b1;
      end
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision plus the purely state-decoded outputs.
  always_comb begin
    state_next = state;
    sccb_start = 1'b0;
    cfg_busy   = 1'b1;
    case (state)
      IDLE: begin
        cfg_busy = 1'b0;
        if (cfg_start) state_next = FETCH;
      end
      FETCH: state_next = DECODE;
      DECODE: begin
        if (rom_data == END_MARKER)        state_next = DONE;
        else if (rom_data == DELAY_MARKER) state_next = DELAY;
        else                               state_next = SEND;
      end
      SEND: begin
        sccb_start = 1'b1;
        state_next = WAIT_PH;
      end
      WAIT_PH: begin
        if (last_phase)       state_next = GUARD;
        else if (wdog_expire) state_next = DONE;
      end
      GUARD, DELAY: begin
        if (cnt_expire) state_next = at_last_addr ? DONE : FETCH;
      end
      DONE: begin
        cfg_busy   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: ROM address, latched write payload, phase/wait counters and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr    <= '0;
      sub_address <= '0;
      data        <= '0;
      cnt         <= '0;
      phase_cnt   <= '0;
      cfg_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            rom_addr <= '0;
            cfg_done <= 1'b0;
          end
        end
        DECODE: begin
          if (rom_data == DELAY_MARKER) begin
            cnt <= DELAY_CYCLES;
          end else if (rom_data != END_MARKER) begin
            sub_address <= rom_data[15:8];
            data        <= rom_data[7:0];
          end
        end
        SEND: phase_cnt <= '0;
        WAIT_PH: begin
          if (last_phase) begin
            phase_cnt <= '0;
            cnt       <= GUARD_CYCLES;
          end else if (one_phase_done) begin
            phase_cnt <= phase_cnt + 2'd1;
          end
        end
        GUARD, DELAY: begin
          if (cnt_expire) begin
            cnt <= '0;
            if (!at_last_addr) rom_addr <= rom_addr + 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: ;
      endcase
      if (state != DONE && state_next == DONE) begin
        cfg_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_config.sv
// Directed testbench for ov7670_config.
// DUT A (ROM_AW=4, DELAY_CYCLES=100, GUARD_CYCLES=8, TIMEOUT_CYCLES=50) covers the
// main sequence, delay entries, mid-sequence reset and start filtering; DUT B
// (ROM_AW=2) covers the ROM address limit. The timeout scenario is built only
// when OV7670_CFG_TIMEOUT_EN is defined.
module tb_ov7670_config;

  localparam int GUARD_A = 8;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // DUT A signals
  logic        rst_a = 1'b1, start_a = 1'b0, phase_a = 1'b0, sccb_en_a = 1'b1;
  logic [3:0]  rom_addr_a;
  logic [15:0] rom_data_a;
  logic        sccb_start_a, busy_a, done_a;
  logic [7:0]  sub_a, data_a;
  logic [15:0] rom_a [16];
`ifdef OV7670_CFG_TIMEOUT_EN
  logic        error_a;
`endif

  // DUT B signals
  logic        rst_b = 1'b1, start_b = 1'b0, phase_b = 1'b0;
  logic [1:0]  rom_addr_b;
  logic [15:0] rom_data_b;
  logic        sccb_start_b, busy_b, done_b;
  logic [7:0]  sub_b, data_b;
  logic [15:0] rom_b [4];
  int          wr_cnt_b = 0;

  logic [7:0] wr_sub_a [$];
  logic [7:0] wr_dat_a [$];
  int         wr_cyc_a [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ov7670_config #(.ROM_AW(4), .DELAY_CYCLES(100), .GUARD_CYCLES(GUARD_A), .TIMEOUT_CYCLES(50)) dut_a (
    .clk(clk), .rst(rst_a), .cfg_start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .sccb_start(sccb_start_a), .sub_address(sub_a), .data(data_a), .one_phase_done(phase_a),
    .cfg_busy(busy_a), .cfg_done(done_a)
`ifdef OV7670_CFG_TIMEOUT_EN
    , .cfg_error(error_a)
`endif
  );

  ov7670_config #(.ROM_AW(2), .DELAY_CYCLES(100), .GUARD_CYCLES(4), .TIMEOUT_CYCLES(50)) dut_b (
    .clk(clk), .rst(rst_b), .cfg_start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sccb_start(sccb_start_b), .sub_address(sub_b), .data(data_b), .one_phase_done(phase_b),
    .cfg_busy(busy_b), .cfg_done(done_b)
`ifdef OV7670_CFG_TIMEOUT_EN
    , .cfg_error()
`endif
  );

  // Synchronous ROMs with one clock of read latency.
  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];
  always @(posedge clk) rom_data_b <= rom_b[rom_addr_b];

  // SCCB master model for A: three phase pulses, each three clocks apart.
  always begin
    @(negedge clk);
    if (sccb_start_a === 1'b1 && sccb_en_a) begin
      for (int p = 0; p < 3; p++) begin
        repeat (3) @(negedge clk);
        phase_a = 1'b1;
        @(negedge clk);
        phase_a = 1'b0;
      end
    end
  end

  // SCCB master model for B.
  always begin
    @(negedge clk);
    if (sccb_start_b === 1'b1) begin
      for (int p = 0; p < 3; p++) begin
        repeat (2) @(negedge clk);
        phase_b = 1'b1;
        @(negedge clk);
        phase_b = 1'b0;
      end
    end
  end

  // Write monitors.
  always @(negedge clk) begin
    if (sccb_start_a === 1'b1) begin
      wr_sub_a.push_back(sub_a);
      wr_dat_a.push_back(data_a);
      wr_cyc_a.push_back(cyc);
    end
    if (sccb_start_b === 1'b1) wr_cnt_b++;
  end

  task automatic load_rom_a(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    for (int i = 0; i < 16; i++) rom_a[i] = 16'hFFFF;
    rom_a[0] = e0;
    rom_a[1] = e1;
    rom_a[2] = e2;
    wr_sub_a.delete();
    wr_dat_a.delete();
    wr_cyc_a.delete();
  endtask

  task automatic pulse_start_a(output int start_cyc);
    @(negedge clk);
    start_cyc = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    int sc;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (rom_addr_a !== 4'd0)     begin n_err++; $display("[TB] FAIL reset_rom_addr got %0d want 0", rom_addr_a); end
    n_vec++; if (sccb_start_a !== 1'b0)   begin n_err++; $display("[TB] FAIL reset_sccb_start got %b want 0", sccb_start_a); end
    n_vec++; if (sub_a !== 8'h00)         begin n_err++; $display("[TB] FAIL reset_sub_address got %h want 00", sub_a); end
    n_vec++; if (data_a !== 8'h00)        begin n_err++; $display("[TB] FAIL reset_data got %h want 00", data_a); end
    n_vec++; if (busy_a !== 1'b0)         begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy_a); end
    n_vec++; if (done_a !== 1'b0)         begin n_err++; $display("[TB] FAIL reset_done got %b want 0", done_a); end
    rst_a = 1'b0;
    rst_b = 1'b0;
    // Reset must also win over a simultaneous start.
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    @(negedge clk);
    rst_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("[TB] FAIL reset_priority_busy got %b want 0", busy_a); end
    rst_a = 1'b0;
    start_a = 1'b0;
    sc = 0;
  endtask

  task automatic wait_done_a(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) break;
    end
    n_vec++;
    if (i >= budget) begin n_err++; $display("[TB] FAIL %s_timeout got no cfg_done within %0d clocks", name, budget); end
  endtask

  task automatic wait_writes_a(input string name, input int count, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (wr_sub_a.size() >= count) break;
      @(negedge clk);
    end
    n_vec++;
    if (i >= budget) begin n_err++; $display("[TB] FAIL %s_wait got %0d writes want %0d", name, wr_sub_a.size(), count); end
  endtask

  task automatic test_basic_sequence();
    int sc;
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    pulse_start_a(sc);
    n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("[TB] FAIL basic_busy got %b want 1", busy_a); end
    wait_done_a("basic", 500);
    n_vec++; if (wr_sub_a.size() !== 2) begin n_err++; $display("[TB] FAIL basic_count got %0d want 2", wr_sub_a.size()); end
    if (wr_sub_a.size() >= 2) begin
      n_vec++; if ({wr_sub_a[0], wr_dat_a[0]} !== 16'h1280) begin n_err++; $display("[TB] FAIL basic_w0 got %h%h want 1280", wr_sub_a[0], wr_dat_a[0]); end
      n_vec++; if ({wr_sub_a[1], wr_dat_a[1]} !== 16'h1101) begin n_err++; $display("[TB] FAIL basic_w1 got %h%h want 1101", wr_sub_a[1], wr_dat_a[1]); end
      n_vec++; if (wr_cyc_a[1] - wr_cyc_a[0] < GUARD_A) begin n_err++; $display("[TB] FAIL basic_spacing got %0d want >= %0d", wr_cyc_a[1] - wr_cyc_a[0], GUARD_A); end
    end
    n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("[TB] FAIL basic_done_busy got %b want 0", busy_a); end
    @(negedge clk);
    n_vec++; if (done_a !== 1'b1) begin n_err++; $display("[TB] FAIL basic_done_sticky got %b want 1", done_a); end
  endtask

  task automatic test_delay_entry();
    int sc;
    int lat;
    load_rom_a(16'hFFF0, 16'h3A04, 16'hFFFF);
    pulse_start_a(sc);
    wait_done_a("delay", 500);
    n_vec++; if (wr_sub_a.size() !== 1) begin n_err++; $display("[TB] FAIL delay_count got %0d want 1", wr_sub_a.size()); end
    if (wr_sub_a.size() >= 1) begin
      lat = wr_cyc_a[0] - (sc + 2);
      n_vec++; if (lat < 101 || lat > 104) begin n_err++; $display("[TB] FAIL delay_latency got %0d want 101..104", lat); end
      n_vec++; if ({wr_sub_a[0], wr_dat_a[0]} !== 16'h3A04) begin n_err++; $display("[TB] FAIL delay_payload got %h%h want 3A04", wr_sub_a[0], wr_dat_a[0]); end
    end
  endtask

  task automatic test_addr_limit();
    int i;
    for (int k = 0; k < 4; k++) rom_b[k] = 16'h0102;
    wr_cnt_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_b === 1'b1) break;
    end
    n_vec++; if (i >= 600) begin n_err++; $display("[TB] FAIL limit_timeout got no cfg_done within 600 clocks"); end
    repeat (20) @(negedge clk);
    n_vec++; if (wr_cnt_b !== 4)      begin n_err++; $display("[TB] FAIL limit_count got %0d want 4", wr_cnt_b); end
    n_vec++; if (rom_addr_b !== 2'd3) begin n_err++; $display("[TB] FAIL limit_rom_addr got %0d want 3", rom_addr_b); end
    n_vec++; if (done_b !== 1'b1)     begin n_err++; $display("[TB] FAIL limit_done got %b want 1", done_b); end
    n_vec++; if (busy_b !== 1'b0)     begin n_err++; $display("[TB] FAIL limit_busy got %b want 0", busy_b); end
  endtask

  task automatic test_reset_mid_sequence();
    int sc;
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    pulse_start_a(sc);
    wait_writes_a("midrst", 2, 300);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    n_vec++; if (sccb_start_a !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_sccb_start got %b want 0", sccb_start_a); end
    n_vec++; if (rom_addr_a !== 4'd0)   begin n_err++; $display("[TB] FAIL midrst_rom_addr got %0d want 0", rom_addr_a); end
    n_vec++; if ({sub_a, data_a} !== 16'h0000) begin n_err++; $display("[TB] FAIL midrst_payload got %h%h want 0000", sub_a, data_a); end
    n_vec++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_flags got busy=%b done=%b want 0 0", busy_a, done_a); end
    rst_a = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++; if (wr_sub_a.size() !== 2) begin n_err++; $display("[TB] FAIL midrst_quiet got %0d writes want 2", wr_sub_a.size()); end
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    pulse_start_a(sc);
    wait_done_a("midrst_restart", 500);
    n_vec++; if (wr_sub_a.size() !== 2) begin n_err++; $display("[TB] FAIL midrst_restart_count got %0d want 2", wr_sub_a.size()); end
    if (wr_sub_a.size() >= 1) begin
      n_vec++; if ({wr_sub_a[0], wr_dat_a[0]} !== 16'h1280) begin n_err++; $display("[TB] FAIL midrst_restart_w0 got %h%h want 1280", wr_sub_a[0], wr_dat_a[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int sc;
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    pulse_start_a(sc);
    wait_writes_a("busy_start", 1, 300);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("busy_start", 500);
    repeat (60) @(negedge clk);
    n_vec++; if (wr_sub_a.size() !== 2) begin n_err++; $display("[TB] FAIL busy_start_count got %0d want 2", wr_sub_a.size()); end
    n_vec++; if (done_a !== 1'b1)       begin n_err++; $display("[TB] FAIL busy_start_done got %b want 1", done_a); end
    // A held start in IDLE after completion restarts and clears the done flag.
    start_a = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin n_err++; $display("[TB] FAIL restart_flags got done=%b busy=%b want 0 1", done_a, busy_a); end
    start_a = 1'b0;
    wait_done_a("restart", 500);
    n_vec++; if (wr_sub_a.size() !== 4) begin n_err++; $display("[TB] FAIL restart_count got %0d want 4", wr_sub_a.size()); end
  endtask

`ifdef OV7670_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int sc;
    int i;
    int s;
    sccb_en_a = 1'b0;
    load_rom_a(16'h1280, 16'h1101, 16'hFFFF);
    pulse_start_a(sc);
    wait_writes_a("timeout", 1, 50);
    s = cyc;
    for (i = 0; i < 200; i++) begin
      if (error_a === 1'b1) break;
      @(negedge clk);
    end
    n_vec++; if (i >= 200) begin n_err++; $display("[TB] FAIL timeout_error got 0 want 1 within 200 clocks"); end
    n_vec++; if (cyc - (s + 1) < 50 || cyc - (s + 1) > 52) begin n_err++; $display("[TB] FAIL timeout_latency got %0d want 50..52", cyc - (s + 1)); end
    n_vec++; if (done_a !== 1'b1) begin n_err++; $display("[TB] FAIL timeout_done got %b want 1", done_a); end
    sccb_en_a = 1'b1;
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom_a[i] = 16'hFFFF;
    for (int i = 0; i < 4; i++) rom_b[i] = 16'hFFFF;
    test_reset();
    test_basic_sequence();
    test_delay_entry();
    test_addr_limit();
    test_reset_mid_sequence();
    test_back_to_back();
`ifdef OV7670_CFG_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ov7670_config.md
OV7670_CONFIG -- requirements
Module: ov7670_config

Interface
REQ-001 Parameter ROM_AW, default 8, ROM address width; the ROM holds 2^ROM_AW entries.
REQ-002 Parameter DELAY_CYCLES, default 1_000_000, length of a delay entry in clocks (10 ms at 100 MHz).
REQ-003 Parameter GUARD_CYCLES, default 32, idle clocks after each SCCB write before the next fetch; legal range 1..255.
REQ-004 Parameter TIMEOUT_CYCLES, default 4096, clocks without one_phase_done before an abort (used only with OV7670_CFG_TIMEOUT_EN).
REQ-005 Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  level or pulse; starts the configuration sequence.
- rom_addr  out  ROM_AW  ROM read address.
- rom_data  in  16  ROM entry {sub_address[15:8], data[7:0]}; valid 1 clock after rom_addr.
- sccb_start  out  1  one-clock request to the SCCB master.
- sub_address  out  8  register address sent to the SCCB master.
- data  out  8  register value sent to the SCCB master.
- one_phase_done  in  1  one-clock pulse from the SCCB master at the end of each of its 3 byte phases.
- cfg_busy  out  1  high while the sequence runs.
- cfg_done  out  1  sticky completion flag.

Function
REQ-006 States: IDLE, FETCH, DECODE, SEND, WAIT_PH, GUARD, DELAY, DONE.
REQ-007 IDLE: when cfg_start=1, the block SHALL load rom_addr=0, clear cfg_done and go to FETCH on the next edge.
REQ-008 FETCH: one wait clock for ROM latency, then go to DECODE.
REQ-009 DECODE, rom_data=16'hFFFF (end marker): go to DONE.
REQ-010 DECODE, rom_data=16'hFFF0 (delay marker): load the delay counter with DELAY_CYCLES and go to DELAY; no SCCB request is issued.
REQ-011 DECODE, any other value: register sub_address=rom_data[15:8] and data=rom_data[7:0], then go to SEND.
REQ-012 SEND: assert sccb_start for exactly one clock, clear the phase counter and go to WAIT_PH.
REQ-013 sub_address and data SHALL stay stable from SEND until the next DECODE of a write entry.
REQ-014 WAIT_PH: count one_phase_done pulses with a 2-bit counter; on the 3rd pulse go to GUARD with the guard counter loaded with GUARD_CYCLES.
REQ-015 GUARD and DELAY: decrement the counter each clock. At count 1, set rom_addr+1 and go to FETCH.
REQ-016 Address limit: if an expiring entry sits at rom_addr = 2^ROM_AW-1, go to DONE instead; rom_addr SHALL never wrap to 0.
REQ-017 DONE: cfg_done=1 and cfg_busy=0, then return to IDLE. cfg_done holds until the next accepted cfg_start or rst.
REQ-018 cfg_busy SHALL be 1 in every state except IDLE and DONE.
REQ-019 cfg_start asserted while cfg_busy=1 SHALL be ignored.
REQ-020 cfg_start held high in IDLE after completion SHALL restart the sequence, which clears cfg_done.
REQ-021 one_phase_done outside WAIT_PH SHALL be ignored. A pulse in the same clock as SEND SHALL NOT be counted.

Reset
REQ-022 On rst=1 at a clock edge, the block SHALL enter IDLE with rom_addr=0, sccb_start=0, sub_address=0, data=0, cfg_busy=0, cfg_done=0, and all counters at 0.
REQ-023 rst takes priority over all other inputs.
REQ-024 rst mid-sequence SHALL drop sccb_start on that edge. No further SCCB request SHALL be issued until a new cfg_start.

Configuration
REQ-025 Macro OV7670_CFG_TIMEOUT_EN.
REQ-026 When defined: add output cfg_error (1 bit, reset 0) and a watchdog that reloads with TIMEOUT_CYCLES on entering WAIT_PH and on each one_phase_done. If it expires, the block SHALL set cfg_error=1 (sticky until the next accepted cfg_start or rst) and go to DONE.
REQ-027 When undefined: no cfg_error port and no watchdog logic; WAIT_PH waits indefinitely.

Verification
REQ-028 ROM {0x1280, 0x1101, 0xFFFF}, SCCB model pulsing one_phase_done 3x per request -> two sccb_start pulses with (0x12,0x80) then (0x11,0x01), writes spaced ≥ GUARD_CYCLES apart, then cfg_done=1 and cfg_busy=0.
REQ-029 ROM {0xFFF0, 0x3A04, 0xFFFF}, DELAY_CYCLES=100 -> first sccb_start is 101-104 clocks after DECODE of entry 0, carrying (0x3A,0x04).
REQ-030 ROM_AW=2, all four entries 0x0102 with no end marker -> exactly 4 writes, cfg_done=1, rom_addr stops at 3.
REQ-031 rst asserted one clock after sccb_start of the 2nd write -> outputs at reset values the next clock; no sccb_start until cfg_start is reasserted, then the sequence restarts at address 0.
REQ-032 cfg_start pulsed during WAIT_PH -> no effect; the sequence completes once.
REQ-033 With OV7670_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=50, SCCB model silent -> cfg_error=1 and cfg_done=1 after 50-52 clocks in WAIT_PH.
